// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the push-button conditioning front end.
// Holds the active button level, the repeat-state type and the counter-width helper.
package key_pkg;

   localparam logic KEY_ACTIVE_LEVEL = 1'b0;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      REPEAT
   } rpt_state_e;

   // Width needed to hold max_val; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      if (max_val < 1) begin
         return 1;
      end
      return $clog2(max_val + 1);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_conditioner_channel.sv
// One button channel: two-flop synchroniser, debouncer and auto-repeat FSM.
// All outputs are registered; strobes last exactly one clock.
module key_channel
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 100000,
   parameter int unsigned HOLD_CYCLES     = 5000000,
   parameter int unsigned REPEAT_CYCLES   = 1000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic repeat_o
);

   localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES - 1);
   localparam int unsigned TM_W = cnt_width(max_u(HOLD_CYCLES - 1, REPEAT_CYCLES - 1));
   localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TM_W-1:0] HOLD_MAX = TM_W'(HOLD_CYCLES - 1);
   localparam logic [TM_W-1:0] RPT_MAX  = TM_W'(REPEAT_CYCLES - 1);

   logic            s1_q;
   logic            s2_q;
   logic            pressed_q;
   logic            pressed_d;
   logic [DB_W-1:0] db_cnt_q;
   logic [DB_W-1:0] db_cnt_d;
   logic            raw_pressed;
   logic            differ;
   logic            accept;
   logic            press_evt;
   logic            release_evt;

   rpt_state_e      state_q;
   logic [TM_W-1:0] tmr_q;
   logic            press_q;
   logic            release_q;
   logic            repeat_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= key_raw_i;
         s2_q <= s1_q;
      end
   end

   // The counter only ever reaches DB_MAX while s2 differs, and that edge accepts
   // and clears, so it saturates without an explicit clamp.
   always_comb begin
      raw_pressed = (s2_q == KEY_ACTIVE_LEVEL);
      differ      = (raw_pressed != pressed_q);
      accept      = differ && (db_cnt_q == DB_MAX);
      db_cnt_d    = '0;
      if (differ && !accept) begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
      pressed_d   = accept ? raw_pressed : pressed_q;
      press_evt   = accept && raw_pressed;
      release_evt = accept && !raw_pressed;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pressed_q <= 1'b0;
         db_cnt_q  <= '0;
      end else begin
         pressed_q <= pressed_d;
         db_cnt_q  <= db_cnt_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         tmr_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         press_q   <= press_evt;
         release_q <= release_evt;
         repeat_q  <= 1'b0;
         if (release_evt) begin
            state_q <= IDLE;
            tmr_q   <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  tmr_q <= '0;
                  if (press_evt) begin
                     state_q <= HOLD;
                  end
               end
               HOLD: begin
                  if (tmr_q == HOLD_MAX) begin
                     repeat_q <= 1'b1;
                     state_q  <= REPEAT;
                     tmr_q    <= '0;
                  end else begin
                     tmr_q <= tmr_q + 1'b1;
                  end
               end
               REPEAT: begin
                  if (tmr_q == RPT_MAX) begin
                     repeat_q <= 1'b1;
                     tmr_q    <= '0;
                  end else begin
                     tmr_q <= tmr_q + 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  tmr_q   <= '0;
               end
            endcase
         end
      end
   end

   assign level_o   = pressed_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// Push-button front end: NUM_KEYS independent debounced channels with
// press, release and auto-repeat strobes, all in the ADC_CLK_10 domain.
module key_conditioner
   import key_pkg::*;
#(
   parameter int unsigned NUM_KEYS        = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 100000,
   parameter int unsigned HOLD_CYCLES     = 5000000,
   parameter int unsigned REPEAT_CYCLES   = 1000000
) (
   input  logic                ADC_CLK_10,
   input  logic                RESET_N,
   input  logic [NUM_KEYS-1:0] KEY,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_repeat
);

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
      key_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_ch (
         .clk_i     (ADC_CLK_10),
         .rst_ni    (RESET_N),
         .key_raw_i (KEY[k]),
         .level_o   (key_level[k]),
         .press_o   (key_press[k]),
         .release_o (key_release[k]),
         .repeat_o  (key_repeat[k])
      );
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed plan steps plus random bouncing,
// compared every cycle against a sliding-window behavioural model.
module tb_key_conditioner;

   localparam int unsigned NK = 2;
   localparam int DB = 4;
   localparam int HC = 10;
   localparam int RC = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NK-1:0] key = '1;
   logic [NK-1:0] key_level;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;
   logic [NK-1:0] key_repeat;

   key_conditioner #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (DB),
      .HOLD_CYCLES     (HC),
      .REPEAT_CYCLES   (RC)
   ) dut (
      .ADC_CLK_10  (clk),
      .RESET_N     (rst_n),
      .KEY         (key),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_repeat  (key_repeat)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int edge_n = 0;

   bit rawlog [NK][$];
   bit sampq  [NK][$];
   bit lvl    [NK];
   int pedge  [NK];
   logic [NK-1:0] e_level, e_press, e_rel, e_rep;

   function automatic void model_reset();
      for (int k = 0; k < NK; k++) begin
         rawlog[k].delete();
         rawlog[k].push_back(1'b1);
         rawlog[k].push_back(1'b1);
         sampq[k].delete();
         lvl[k]   = 1'b0;
         pedge[k] = -1000;
      end
      e_level = '0; e_press = '0; e_rel = '0; e_rep = '0;
      edge_n  = 0;
   endfunction

   // A change is accepted once the last DB values seen after two flops of delay all
   // disagree with the current level; repeats follow from the press edge arithmetically.
   function automatic void model_edge(input logic [NK-1:0] raw);
      edge_n++;
      for (int k = 0; k < NK; k++) begin
         bit was, all_diff, seen;
         rawlog[k].push_back(raw[k]);
         seen = rawlog[k][rawlog[k].size() - 3];
         if (rawlog[k].size() > 3) void'(rawlog[k].pop_front());
         sampq[k].push_back(seen);
         if (sampq[k].size() > DB) void'(sampq[k].pop_front());
         was = lvl[k];
         all_diff = (sampq[k].size() == DB);
         foreach (sampq[k][i]) if ((sampq[k][i] == 1'b0) == was) all_diff = 1'b0;
         if (all_diff) lvl[k] = !was;
         e_level[k] = lvl[k];
         e_press[k] = !was && lvl[k];
         e_rel[k]   = was && !lvl[k];
         if (e_press[k]) pedge[k] = edge_n;
         e_rep[k] = lvl[k] && !e_press[k] && (edge_n - pedge[k] >= HC)
                    && (((edge_n - pedge[k] - HC) % RC) == 0);
      end
   endfunction

   task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("level",   key_level,   e_level);
      chk("press",   key_press,   e_press);
      chk("release", key_release, e_rel);
      chk("repeat",  key_repeat,  e_rep);
   endtask

   // Drive while the clock is low, let the model see the sampled value, check after the edge.
   task automatic cyc(input logic [NK-1:0] k_in);
      key = k_in;
      @(posedge clk);
      model_edge(key);
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      repeat (n) begin
         @(negedge clk);
         check_all();
      end
      rst_n = 1'b1;
   endtask

   int first, cnt;
   int rep_edges[$];

   initial begin
      model_reset();
      @(negedge clk);
      do_reset(2);

      // Idle with keys released
      repeat (20) cyc(2'b11);

      // Single press, held into repeat, then released just after the fourth repeat
      first = -1;
      rep_edges.delete();
      for (int i = 1; i <= 25; i++) begin
         cyc(2'b10);
         if (key_press[0] && first < 0) first = i;
         if (key_repeat[0]) rep_edges.push_back(i);
         if (i == 6) chk("level1_idle", key_level[1], 1'b0);
         if (i == 7) chk("press_one_cycle", key_press, 2'b00);
      end
      chk_int("press_edge", first, 6);
      chk_int("repeat_count", rep_edges.size(), 4);
      for (int j = 0; j < 4; j++) begin
         if (j < rep_edges.size()) chk_int("repeat_offset", rep_edges[j] - first, 10 + 3 * j);
      end
      first = -1;
      cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         cyc(2'b11);
         if (key_release[0] && first < 0) first = i;
         if (key_repeat[0] && i >= 6) cnt++;
      end
      chk_int("release_edge", first, 6);
      chk_int("repeat_after_release", cnt, 0);

      // Bounce 0,1,0,1,0 then steady low
      first = -1;
      cnt = 0;
      begin
         logic [NK-1:0] pat [5] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
         for (int i = 1; i <= 14; i++) begin
            cyc(i <= 5 ? pat[i-1] : 2'b10);
            if (key_press[0]) begin
               cnt++;
               if (first < 0) first = i;
            end
         end
      end
      chk_int("bounce_press_edge", first, 10);
      chk_int("bounce_press_count", cnt, 1);
      repeat (10) cyc(2'b11);

      // Simultaneous press and release on both keys
      for (int i = 1; i <= 8; i++) begin
         cyc(2'b00);
         if (i == 6) chk("both_press", key_press, 2'b11);
      end
      for (int i = 1; i <= 8; i++) begin
         cyc(2'b11);
         if (i == 6) chk("both_release", key_release, 2'b11);
      end

      // Reset in the middle of REPEAT with key 0 still held
      repeat (20) cyc(2'b10);
      key = 2'b10;
      do_reset(3);
      first = -1;
      cnt = 0;
      for (int i = 1; i <= 12; i++) begin
         cyc(2'b10);
         if (key_press[0] && first < 0) first = i;
         if (key_release[0]) cnt++;
      end
      chk_int("post_reset_press_edge", first, 6);
      chk_int("post_reset_release_count", cnt, 0);
      repeat (10) cyc(2'b11);

      // Random bouncing and holds on both keys
      for (int s = 0; s < 80; s++) begin
         logic [NK-1:0] v;
         int len;
         v = NK'($urandom_range(0, 3));
         len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(15, 30)) : int'($urandom_range(1, 7));
         repeat (len) cyc(v);
      end
      repeat (12) cyc(2'b11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
